// File: rtl/regwrite_decoder_sb.sv
// Multi-port register-file write-strobe decoder with registered strobes and a
// one-bit-per-register busy scoreboard feeding decode-stage hazard checks.

module regwrite_port_dec #(
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int ZERO_EN  = 1,
  parameter int ZERO_REG = 31
) (
  input  logic                en,
  input  logic [ADDR_W-1:0]   addr,
  output logic [NUM_REGS-1:0] vec
);
  localparam logic [NUM_REGS-1:0] ONE  = NUM_REGS'(1);
  localparam logic [NUM_REGS-1:0] KEEP = (ZERO_EN != 0) ? ~(ONE << ZERO_REG) : '1;

  assign vec = en ? ((ONE << addr) & KEEP) : '0;
endmodule

module regwrite_decoder_sb #(
  parameter int ADDR_W    = 5,
  parameter int NUM_REGS  = 32,
  parameter int NUM_PORTS = 2,
  parameter int ZERO_EN   = 1,
  parameter int ZERO_REG  = 31
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_PORTS-1:0]          wr_en,
  input  logic [NUM_PORTS*ADDR_W-1:0]   wr_addr,
  output logic [NUM_PORTS*NUM_REGS-1:0] we_port,
  output logic [NUM_REGS-1:0]           we_any,
  output logic                          conflict,
  input  logic                          iss_valid,
  input  logic [ADDR_W-1:0]             iss_addr,
  output logic [NUM_REGS-1:0]           busy,
  input  logic [ADDR_W-1:0]             rd_addr_a,
  input  logic [ADDR_W-1:0]             rd_addr_b,
  output logic                          hazard_a,
  output logic                          hazard_b
);
  logic [NUM_PORTS-1:0][NUM_REGS-1:0] dec, hi, kept;
  logic [NUM_REGS-1:0]                iss_vec, clr, any_n;
  logic                               coll;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    regwrite_port_dec #(
      .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .ZERO_EN(ZERO_EN), .ZERO_REG(ZERO_REG)
    ) u_dec (
      .en(wr_en[p]), .addr(wr_addr[p*ADDR_W +: ADDR_W]), .vec(dec[p])
    );
  end

  regwrite_port_dec #(
    .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .ZERO_EN(ZERO_EN), .ZERO_REG(ZERO_REG)
  ) u_iss (
    .en(iss_valid), .addr(iss_addr), .vec(iss_vec)
  );

  // hi[p] = union of all higher ports; a lower port loses any bit a higher one claims
  always_comb begin
    hi    = '0;
    kept  = '0;
    clr   = '0;
    any_n = '0;
    coll  = 1'b0;
    for (int p = NUM_PORTS - 2; p >= 0; p--)
      hi[p] = hi[p+1] | dec[p+1];
    for (int p = 0; p < NUM_PORTS; p++) begin
      kept[p] = dec[p] & ~hi[p];
      coll    = coll | (|(dec[p] & hi[p]));
      clr     = clr | dec[p];
      any_n   = any_n | kept[p];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_port  <= '0;
      we_any   <= '0;
      conflict <= 1'b0;
      busy     <= '0;
    end else begin
      we_port  <= kept;
      we_any   <= any_n;
      conflict <= coll;
      // issue is younger than the writeback, so set overrides clear
      busy     <= (busy & ~clr) | iss_vec;
    end
  end

  assign hazard_a = busy[rd_addr_a];
  assign hazard_b = busy[rd_addr_b];
endmodule
